// File: rtl/simon_seq_if.sv
// ============================================================================
//  Module      : simon_seq_if
//  Description : Front-end bus of the Simon game engine. The master side is
//                the button/LED front end, the slave side is the engine.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface simon_seq_if #(
    parameter int BTN_W = 2,
    parameter int LEN_W = 5
);
    logic             start;
    logic [BTN_W-1:0] player_num;
    logic             player_pressed;
    logic             simon_turn;
    logic [BTN_W-1:0] simon_num;
    logic             simon_pressed;
    logic [LEN_W-1:0] level;
    logic             game_over;
    logic             game_won;

    // Front end: drives start and the player buttons, watches the engine
    modport master (
        output start, player_num, player_pressed,
        input  simon_turn, simon_num, simon_pressed, level, game_over, game_won
    );

    // Engine: consumes start and the buttons, produces playback and status
    modport slave (
        input  start, player_num, player_pressed,
        output simon_turn, simon_num, simon_pressed, level, game_over, game_won
    );
endinterface

`default_nettype wire

// File: rtl/simon_seq.sv
// ============================================================================
//  Module      : simon_seq
//  Description : Parametrised Simon memory-game engine. Grows a random
//                sequence, plays it back with programmable on/off timing and
//                checks the player's echo with a per-press timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simon_seq #(
    parameter int          BTN_W         = 2,
    parameter int          MAX_LEN       = 16,
    parameter int          LEN_W         = 5,
    parameter int          ON_TICKS      = 30,
    parameter int          OFF_TICKS     = 15,
    parameter int          TIMEOUT_TICKS = 300,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  wire logic   clk,
    input  wire logic   reset,
    simon_seq_if.slave  bus
);

    // Timer must hold the largest terminal count of the three phases
    localparam int c_TMR_MAX = (TIMEOUT_TICKS > ON_TICKS) ?
                               ((TIMEOUT_TICKS > OFF_TICKS) ? TIMEOUT_TICKS : OFF_TICKS) :
                               ((ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS);
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);
    localparam int c_IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [c_TMR_W-1:0] c_ON_LAST  = c_TMR_W'(ON_TICKS - 1);
    localparam logic [c_TMR_W-1:0] c_OFF_LAST = c_TMR_W'(OFF_TICKS - 1);
    localparam logic [c_TMR_W-1:0] c_TO_LAST  = c_TMR_W'(TIMEOUT_TICKS - 1);
    localparam logic [LEN_W-1:0]   c_MAX_LVL  = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_ADD          = 3'd1,
        S_SHOW_ON      = 3'd2,
        S_SHOW_OFF     = 3'd3,
        S_WAIT_PRESS   = 3'd4,
        S_WAIT_RELEASE = 3'd5,
        S_LOSE         = 3'd6,
        S_WIN          = 3'd7
    } state_t;

    state_t             r_state;
    logic [15:0]        r_lfsr;
    logic               r_pressed_d;
    logic [LEN_W-1:0]   r_level;
    logic [LEN_W-1:0]   r_idx;
    logic [c_TMR_W-1:0] r_timer;
    logic               r_simon_turn;
    logic [BTN_W-1:0]   r_simon_num;
    logic               r_simon_pressed;
    logic               r_game_over;
    logic               r_game_won;
    logic [BTN_W-1:0]   r_seq [MAX_LEN];

    logic [15:0]        w_lfsr_next;
    logic [BTN_W-1:0]   w_new_code;
    logic [LEN_W-1:0]   w_idx_inc;
    logic               w_last;
    logic               w_press_evt;
    logic               w_match;

    // Galois LFSR, taps 16,14,13,11 (mask 0xB400), shifting right
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_new_code  = r_lfsr[BTN_W-1:0];
    assign w_idx_inc   = r_idx + 1'b1;
    assign w_last      = (r_idx == (r_level - 1'b1));
    // Only a fresh rising edge counts; a button held over from playback does not
    assign w_press_evt = bus.player_pressed && !r_pressed_d;
    assign w_match     = (bus.player_num == r_seq[r_idx[c_IDX_W-1:0]]);

    // Sequence storage: written once per round in ADD, deliberately not reset
    always_ff @(posedge clk) begin
        if (r_state == S_ADD) begin
            r_seq[r_level[c_IDX_W-1:0]] <= w_new_code;
        end
    end

    // Game controller: state, timers, LFSR and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_lfsr          <= SEED;
            r_pressed_d     <= 1'b0;
            r_level         <= '0;
            r_idx           <= '0;
            r_timer         <= '0;
            r_simon_turn    <= 1'b0;
            r_simon_num     <= '0;
            r_simon_pressed <= 1'b0;
            r_game_over     <= 1'b0;
            r_game_won      <= 1'b0;
        end else begin
            r_lfsr      <= w_lfsr_next;
            r_pressed_d <= bus.player_pressed;

            case (r_state)
                S_IDLE, S_LOSE, S_WIN: begin
                    if (bus.start) begin
                        r_level         <= '0;
                        r_idx           <= '0;
                        r_timer         <= '0;
                        r_simon_turn    <= 1'b0;
                        r_simon_pressed <= 1'b0;
                        r_game_over     <= 1'b0;
                        r_game_won      <= 1'b0;
                        r_state         <= S_ADD;
                    end
                end

                S_ADD: begin
                    // Element 0 is only brand new on the first round; the
                    // array write lands this edge, so bypass it here
                    r_simon_num     <= (r_level == '0) ? w_new_code : r_seq[0];
                    r_level         <= r_level + 1'b1;
                    r_idx           <= '0;
                    r_timer         <= '0;
                    r_simon_turn    <= 1'b1;
                    r_simon_pressed <= 1'b1;
                    r_state         <= S_SHOW_ON;
                end

                S_SHOW_ON: begin
                    if (r_timer == c_ON_LAST) begin
                        r_timer         <= '0;
                        r_simon_pressed <= 1'b0;
                        r_state         <= S_SHOW_OFF;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_SHOW_OFF: begin
                    if (r_timer == c_OFF_LAST) begin
                        r_timer <= '0;
                        if (w_last) begin
                            r_idx        <= '0;
                            r_simon_turn <= 1'b0;
                            r_state      <= S_WAIT_PRESS;
                        end else begin
                            r_idx           <= w_idx_inc;
                            r_simon_num     <= r_seq[w_idx_inc[c_IDX_W-1:0]];
                            r_simon_pressed <= 1'b1;
                            r_state         <= S_SHOW_ON;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_WAIT_PRESS: begin
                    // A press on the final timer cycle still wins over timeout
                    if (w_press_evt) begin
                        if (w_match) begin
                            r_state <= S_WAIT_RELEASE;
                        end else begin
                            r_game_over <= 1'b1;
                            r_state     <= S_LOSE;
                        end
                    end else if (r_timer == c_TO_LAST) begin
                        r_game_over <= 1'b1;
                        r_state     <= S_LOSE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_WAIT_RELEASE: begin
                    if (!bus.player_pressed) begin
                        if (w_last) begin
                            if (r_level == c_MAX_LVL) begin
                                r_game_won <= 1'b1;
                                r_state    <= S_WIN;
                            end else begin
                                r_state <= S_ADD;
                            end
                        end else begin
                            r_idx   <= w_idx_inc;
                            r_timer <= '0;
                            r_state <= S_WAIT_PRESS;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.simon_turn    = r_simon_turn;
    assign bus.simon_num     = r_simon_num;
    assign bus.simon_pressed = r_simon_pressed;
    assign bus.level         = r_level;
    assign bus.game_over     = r_game_over;
    assign bus.game_won      = r_game_won;

endmodule

`default_nettype wire
